// File: rtl/fir_mac_scheduler_pkg.sv
// Shared constants, FSM state type and the dequantize helper for the FIR MAC scheduler.
package fir_mac_scheduler_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BITS       = 10;
  localparam int unsigned MAX_TAPS   = 32;
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} mac_sched_state_t;

  // Drop BITS fractional bits, rounding toward zero for negative products.
  function automatic logic signed [PROD_WIDTH-1:0] dequantize_i(
    input logic signed [PROD_WIDTH-1:0] p
  );
    if (p[PROD_WIDTH-1]) return -((-p) >>> BITS);
    return p >>> BITS;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared multiply / dequantize / accumulate datapath with a single accumulator register.
module fir_mac
  import fir_mac_scheduler_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         mac_en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] samp,
  input  logic signed [DATA_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0] acc
);

  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [DATA_WIDTH-1:0] term_c;

  always_comb begin
    prod_c = PROD_WIDTH'(samp) * PROD_WIDTH'(coef);
    term_c = DATA_WIDTH'(dequantize_i(prod_c));
  end

  // Accumulator wraps in two's complement; clear wins over accumulate.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    acc <= '0;
    else if (clr)    acc <= '0;
    else if (mac_en) acc <= acc + term_c;
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one FIR MAC among NUM_REQ clients, one result per job.
module fir_mac_scheduler
  import fir_mac_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAPS    = MAX_TAPS
)(
  input  logic                                                  clock,
  input  logic                                                  reset_n,
  input  logic [NUM_REQ-1:0]                                    req_valid,
  output logic [NUM_REQ-1:0]                                    req_grant,
  output logic                                                  rd_en,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]      rd_sel,
  output logic [$clog2(TAPS)-1:0]                               rd_tap,
  input  logic signed [DATA_WIDTH-1:0]                          samp_rdata,
  input  logic signed [DATA_WIDTH-1:0]                          coef_rdata,
  output logic                                                  res_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]      res_id,
  output logic signed [DATA_WIDTH-1:0]                          res_data,
  input  logic                                                  res_ready,
  output logic                                                  busy
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAP_W = $clog2(TAPS);

  mac_sched_state_t              state;
  logic [ID_W-1:0]               rr_ptr;
  logic [ID_W-1:0]               cur_id;
  logic [ID_W-1:0]               winner_c;
  logic [TAP_W-1:0]              tap;
  logic                          mac_en;
  logic                          clr_c;
  logic signed [DATA_WIDTH-1:0]  acc;

  function automatic logic [ID_W-1:0] rr_offset(input logic [ID_W-1:0] base,
                                                input int unsigned k);
    return ID_W'((32'(base) + k) % NUM_REQ);
  endfunction

  // Scan from the far end so the requester closest to rr_ptr is written last.
  always_comb begin
    winner_c = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_offset(rr_ptr, 32'(k))]) winner_c = rr_offset(rr_ptr, 32'(k));
    end
  end

  assign clr_c    = (state == S_IDLE) && (|req_valid);
  assign res_data = acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      tap       <= '0;
      req_grant <= '0;
      rd_en     <= 1'b0;
      rd_sel    <= '0;
      rd_tap    <= '0;
      mac_en    <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      mac_en    <= rd_en;
      req_grant <= '0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            state     <= S_RUN;
            cur_id    <= winner_c;
            tap       <= '0;
            req_grant <= NUM_REQ'(1) << winner_c;
            rd_en     <= 1'b1;
            rd_sel    <= winner_c;
            rd_tap    <= '0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (tap == TAP_W'(TAPS - 1)) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
          end else begin
            tap    <= tap + 1'b1;
            rd_tap <= tap + 1'b1;
          end
        end
        // Last product lands in acc on this edge, so res_data is final in DONE.
        S_DRAIN: begin
          state     <= S_DONE;
          res_valid <= 1'b1;
          res_id    <= cur_id;
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= rr_offset(cur_id, 1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fir_mac u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .mac_en  (mac_en),
    .clr     (clr_c),
    .samp    (samp_rdata),
    .coef    (coef_rdata),
    .acc     (acc)
  );

endmodule
